serial_compare_ctrl: RTL and testbench

//   Bit-serial equality controller for the WIDTH-bit compare datapath. One
//   1-bit XOR compare stage is shared across all bit positions and driven MSB

---
 rtl/serial_compare_ctrl.sv | 116 +++++++++++
 tb/tb_serial_compare_ctrl.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_compare_ctrl.sv
// Purpose  : bit-serial equality compare of two WIDTH-bit operands, MSB first, one bit per clock,
//            reporting whether they differ and the index of the highest differing bit.
// Latency  : WIDTH-k clocks accept->done_valid (k = highest differing bit, EARLY_EXIT=1),
//            WIDTH clocks for equal operands or EARLY_EXIT=0.
// Backpres.: start_ready only in IDLE (no queueing). The result is held in DONE until done_ready.
// Ports    : clk/rst_n (async active-low); start_valid/start_ready/a/b operand handshake;
//            done_valid/done_ready/diff/first_idx result handshake; busy = SCAN or DONE.
module serial_compare_ctrl #(
    parameter int WIDTH      = 6,
    parameter bit EARLY_EXIT = 1'b1,
    localparam int IDXW      = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_valid,
    output logic             start_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             done_valid,
    input  logic             done_ready,
    output logic             diff,
    output logic [IDXW-1:0]  first_idx,
    output logic             busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(WIDTH - 1);

    state_t            r_state;
    state_t            w_next_state;
    logic [WIDTH-1:0]  r_a;
    logic [WIDTH-1:0]  r_b;
    logic [IDXW-1:0]   r_idx;
    logic              r_mis;      // a mismatch has been seen in this scan
    logic [IDXW-1:0]   r_hit_idx;  // index of the highest mismatch seen in this scan
    logic              r_diff;
    logic [IDXW-1:0]   r_first_idx;

    logic              w_accept;
    logic              w_bit_ne;
    logic              w_scan_end;

    // The single shared 1-bit compare stage.
    assign w_bit_ne   = r_a[r_idx] ^ r_b[r_idx];
    assign w_accept   = (r_state == IDLE) && start_valid;
    // idx==0 ends the scan, so the decrement never wraps.
    assign w_scan_end = (EARLY_EXIT && w_bit_ne) || (r_idx == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:    if (start_valid) w_next_state = SCAN;
            SCAN:    if (w_scan_end)  w_next_state = DONE;
            DONE:    if (done_ready)  w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a         <= '0;
            r_b         <= '0;
            r_idx       <= '0;
            r_mis       <= 1'b0;
            r_hit_idx   <= '0;
            r_diff      <= 1'b0;
            r_first_idx <= '0;
        end else if (w_accept) begin
            r_a       <= a;
            r_b       <= b;
            r_idx     <= LAST_IDX;
            r_mis     <= 1'b0;
            r_hit_idx <= '0;
        end else if (r_state == SCAN) begin
            // Scanning MSB first: only the first mismatch recorded is the highest one.
            if (w_bit_ne && !r_mis) begin
                r_mis     <= 1'b1;
                r_hit_idx <= r_idx;
            end
            if (w_scan_end) begin
                // Published outputs change only here, so they keep the previous
                // result throughout IDLE and the next scan.
                r_diff <= r_mis | w_bit_ne;
                if (r_mis) begin
                    r_first_idx <= r_hit_idx;
                end else if (w_bit_ne) begin
                    r_first_idx <= r_idx;
                end else begin
                    r_first_idx <= '0;
                end
            end else begin
                r_idx <= r_idx - 1'b1;
            end
        end
    end

    assign start_ready = (r_state == IDLE);
    assign done_valid  = (r_state == DONE);
    assign busy        = (r_state != IDLE);
    assign diff        = r_diff;
    assign first_idx   = r_first_idx;

endmodule

// File: tb/tb_serial_compare_ctrl.sv
module tb_serial_compare_ctrl;

    logic       clk;
    logic       rst_n;
    logic [5:0] a;
    logic [5:0] b;

    // Early-exit instance
    logic       sv_ee, sr_ee, dv_ee, dr_ee, diff_ee, busy_ee;
    logic [2:0] idx_ee;
    // Full-scan instance
    logic       sv_fs, sr_fs, dv_fs, dr_fs, diff_fs, busy_fs;
    logic [2:0] idx_fs;

    integer checks;
    integer errors;

    serial_compare_ctrl #(.WIDTH(6), .EARLY_EXIT(1'b1)) u_ee (
        .clk(clk), .rst_n(rst_n),
        .start_valid(sv_ee), .start_ready(sr_ee), .a(a), .b(b),
        .done_valid(dv_ee), .done_ready(dr_ee),
        .diff(diff_ee), .first_idx(idx_ee), .busy(busy_ee)
    );

    serial_compare_ctrl #(.WIDTH(6), .EARLY_EXIT(1'b0)) u_fs (
        .clk(clk), .rst_n(rst_n),
        .start_valid(sv_fs), .start_ready(sr_fs), .a(a), .b(b),
        .done_valid(dv_fs), .done_ready(dr_fs),
        .diff(diff_fs), .first_idx(idx_fs), .busy(busy_fs)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Offers operands to the early-exit instance, then counts clocks from the accept
    // edge until done_valid (-1 if it never rises). Operands are scrambled right after
    // the accept edge so that only the sampled values can influence the result.
    task automatic start_ee(input logic [5:0] ta, input logic [5:0] tb_v, output int lat);
        @(negedge clk);
        a = ta; b = tb_v; sv_ee = 1'b1;
        @(posedge clk);
        #1;
        sv_ee = 1'b0;
        a = ~ta; b = tb_v ^ 6'b101010;
        lat = -1;
        for (int i = 1; i <= 20 && lat < 0; i++) begin
            @(posedge clk);
            #1;
            if (dv_ee) lat = i;
        end
    endtask

    task automatic start_fs(input logic [5:0] ta, input logic [5:0] tb_v, output int lat);
        @(negedge clk);
        a = ta; b = tb_v; sv_fs = 1'b1;
        @(posedge clk);
        #1;
        sv_fs = 1'b0;
        a = ~ta; b = ~tb_v;
        lat = -1;
        for (int i = 1; i <= 20 && lat < 0; i++) begin
            @(posedge clk);
            #1;
            if (dv_fs) lat = i;
        end
    endtask

    task automatic consume_ee();
        @(negedge clk);
        dr_ee = 1'b1;
        @(posedge clk);
        #1;
        dr_ee = 1'b0;
    endtask

    task automatic consume_fs();
        @(negedge clk);
        dr_fs = 1'b1;
        @(posedge clk);
        #1;
        dr_fs = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks += 5;
        if (sr_ee !== 1'b1)  begin errors++; $display("FAIL reset_start_ready got %b exp 1", sr_ee); end
        if (dv_ee !== 1'b0)  begin errors++; $display("FAIL reset_done_valid got %b exp 0", dv_ee); end
        if (diff_ee !== 1'b0) begin errors++; $display("FAIL reset_diff got %b exp 0", diff_ee); end
        if (idx_ee !== 3'd0) begin errors++; $display("FAIL reset_first_idx got %0d exp 0", idx_ee); end
        if (busy_ee !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy_ee); end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_early_exit();
        int lat;
        // xor = 001110, highest differing bit 3
        start_ee(6'b001010, 6'b000100, lat);
        checks += 5;
        if (lat != 3)         begin errors++; $display("FAIL ee_mid_lat got %0d exp 3", lat); end
        if (diff_ee !== 1'b1) begin errors++; $display("FAIL ee_mid_diff got %b exp 1", diff_ee); end
        if (idx_ee !== 3'd3)  begin errors++; $display("FAIL ee_mid_idx got %0d exp 3", idx_ee); end
        if (busy_ee !== 1'b1) begin errors++; $display("FAIL ee_mid_busy got %b exp 1", busy_ee); end
        if (sr_ee !== 1'b0)   begin errors++; $display("FAIL ee_mid_start_ready got %b exp 0", sr_ee); end
        consume_ee();
        checks += 4;
        if (dv_ee !== 1'b0)   begin errors++; $display("FAIL ee_consume_dv got %b exp 0", dv_ee); end
        if (sr_ee !== 1'b1)   begin errors++; $display("FAIL ee_consume_sr got %b exp 1", sr_ee); end
        if (diff_ee !== 1'b1) begin errors++; $display("FAIL ee_keep_diff got %b exp 1", diff_ee); end
        if (idx_ee !== 3'd3)  begin errors++; $display("FAIL ee_keep_idx got %0d exp 3", idx_ee); end
    endtask

    task automatic test_equal_and_msb();
        int lat;
        start_ee(6'b000001, 6'b000001, lat);
        checks += 3;
        if (lat != 6)         begin errors++; $display("FAIL eq_lat got %0d exp 6", lat); end
        if (diff_ee !== 1'b0) begin errors++; $display("FAIL eq_diff got %b exp 0", diff_ee); end
        if (idx_ee !== 3'd0)  begin errors++; $display("FAIL eq_idx got %0d exp 0", idx_ee); end
        consume_ee();
        start_ee(6'b100000, 6'b000001, lat);
        checks += 3;
        if (lat != 1)         begin errors++; $display("FAIL msb_lat got %0d exp 1", lat); end
        if (diff_ee !== 1'b1) begin errors++; $display("FAIL msb_diff got %b exp 1", diff_ee); end
        if (idx_ee !== 3'd5)  begin errors++; $display("FAIL msb_idx got %0d exp 5", idx_ee); end
        consume_ee();
    endtask

    task automatic test_backpressure();
        int lat;
        // Accept 000011 vs 000001 (differs at bit 1 -> 5 clocks), with a stray start in SCAN.
        @(negedge clk);
        a = 6'b000011; b = 6'b000001; sv_ee = 1'b1;
        @(posedge clk);
        #1;
        sv_ee = 1'b0;
        @(negedge clk);
        a = 6'b100000; b = 6'b000000; sv_ee = 1'b1;
        checks += 1;
        if (sr_ee !== 1'b0) begin errors++; $display("FAIL bp_scan_sr got %b exp 0", sr_ee); end
        @(posedge clk);
        #1;
        sv_ee = 1'b0;
        lat = -1;
        for (int i = 2; i <= 20 && lat < 0; i++) begin
            @(posedge clk);
            #1;
            if (dv_ee) lat = i;
        end
        checks += 1;
        if (lat != 5) begin errors++; $display("FAIL bp_lat got %0d exp 5", lat); end
        // Hold done_ready low for 5 cycles, pulsing start_valid meanwhile.
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            sv_ee = (i == 2);
            checks += 4;
            if (dv_ee !== 1'b1)   begin errors++; $display("FAIL bp_hold_dv cyc %0d got %b exp 1", i, dv_ee); end
            if (diff_ee !== 1'b1) begin errors++; $display("FAIL bp_hold_diff cyc %0d got %b exp 1", i, diff_ee); end
            if (idx_ee !== 3'd1)  begin errors++; $display("FAIL bp_hold_idx cyc %0d got %0d exp 1", i, idx_ee); end
            if (sr_ee !== 1'b0)   begin errors++; $display("FAIL bp_hold_sr cyc %0d got %b exp 0", i, sr_ee); end
        end
        @(negedge clk);
        sv_ee = 1'b0;
        consume_ee();
        // No queued start: still idle a few cycles later, even with a stray done_ready.
        @(negedge clk);
        dr_ee = 1'b1;
        @(negedge clk);
        dr_ee = 1'b0;
        @(negedge clk);
        checks += 4;
        if (busy_ee !== 1'b0) begin errors++; $display("FAIL bp_noqueue_busy got %b exp 0", busy_ee); end
        if (sr_ee !== 1'b1)   begin errors++; $display("FAIL bp_idle_sr got %b exp 1", sr_ee); end
        if (diff_ee !== 1'b1) begin errors++; $display("FAIL bp_idle_diff got %b exp 1", diff_ee); end
        if (idx_ee !== 3'd1)  begin errors++; $display("FAIL bp_idle_idx got %0d exp 1", idx_ee); end
    endtask

    task automatic test_full_scan();
        int lat;
        // xor = 010001: bits 4 and 0 differ, the highest (4) is reported.
        start_fs(6'b010000, 6'b000001, lat);
        checks += 3;
        if (lat != 6)         begin errors++; $display("FAIL fs_lat got %0d exp 6", lat); end
        if (diff_fs !== 1'b1) begin errors++; $display("FAIL fs_diff got %b exp 1", diff_fs); end
        if (idx_fs !== 3'd4)  begin errors++; $display("FAIL fs_idx got %0d exp 4", idx_fs); end
        consume_fs();
        start_fs(6'b110101, 6'b110101, lat);
        checks += 3;
        if (lat != 6)         begin errors++; $display("FAIL fs_eq_lat got %0d exp 6", lat); end
        if (diff_fs !== 1'b0) begin errors++; $display("FAIL fs_eq_diff got %b exp 0", diff_fs); end
        if (idx_fs !== 3'd0)  begin errors++; $display("FAIL fs_eq_idx got %0d exp 0", idx_fs); end
        consume_fs();
    endtask

    task automatic test_reset_mid_scan();
        int lat;
        @(negedge clk);
        a = 6'b000001; b = 6'b000001; sv_ee = 1'b1;
        @(posedge clk);
        #1;
        sv_ee = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checks += 5;
        if (sr_ee !== 1'b1)   begin errors++; $display("FAIL rst_scan_sr got %b exp 1", sr_ee); end
        if (dv_ee !== 1'b0)   begin errors++; $display("FAIL rst_scan_dv got %b exp 0", dv_ee); end
        if (diff_ee !== 1'b0) begin errors++; $display("FAIL rst_scan_diff got %b exp 0", diff_ee); end
        if (idx_ee !== 3'd0)  begin errors++; $display("FAIL rst_scan_idx got %0d exp 0", idx_ee); end
        if (busy_ee !== 1'b0) begin errors++; $display("FAIL rst_scan_busy got %b exp 0", busy_ee); end
        @(negedge clk);
        rst_n = 1'b1;
        start_ee(6'b100000, 6'b000001, lat);
        checks += 3;
        if (lat != 1)         begin errors++; $display("FAIL rst_after_lat got %0d exp 1", lat); end
        if (diff_ee !== 1'b1) begin errors++; $display("FAIL rst_after_diff got %b exp 1", diff_ee); end
        if (idx_ee !== 3'd5)  begin errors++; $display("FAIL rst_after_idx got %0d exp 5", idx_ee); end
        consume_ee();
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_n  = 1'b0;
        a      = '0;
        b      = '0;
        sv_ee  = 1'b0;
        dr_ee  = 1'b0;
        sv_fs  = 1'b0;
        dr_fs  = 1'b0;
        test_reset();
        test_early_exit();
        test_equal_and_msb();
        test_backpressure();
        test_full_scan();
        test_reset_mid_scan();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
